// File: rtl/fetch_ifu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ifu_ctrl
// Function : instruction-fetch sequencer feeding MBR1/MBR2 from a prefetch queue
// Revision : 1.0
// ============================================================================
module fetch_ifu_ctrl #(
    parameter int          QDEPTH   = 6,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk_ifu,
    input  logic        reset_ifu,
    input  logic        ifu_enable,
    input  logic        pc_load,
    input  logic [31:0] pc_in,
    output logic [31:0] mem_pc,
    output logic        mem_fetch,
    input  logic [7:0]  mem_byte,
    output logic [7:0]  mbr1,
    output logic        mbr1_valid,
    output logic [15:0] mbr2,
    output logic        mbr2_valid,
    input  logic        consume1,
    input  logic        consume2,
    output logic [31:0] pc_head,
    output logic [3:0]  q_count,
    output logic        err_underflow
);
    localparam int            PW       = (QDEPTH > 8) ? 4 : (QDEPTH > 4) ? 3 : (QDEPTH > 2) ? 2 : 1;
    localparam logic [3:0]    C_QDEPTH = 4'(QDEPTH);
    localparam logic [PW-1:0] C_LAST   = PW'(QDEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2
    } state_t;

    state_t        r_state, w_state_next;
    logic [7:0]    r_q [QDEPTH];
    logic [PW-1:0] r_rd_ptr, r_wr_ptr, w_rd_p1, w_rd_next;
    logic [3:0]    r_count, w_count_next;
    logic [31:0]   r_fetch_pc, r_pc_head, r_mem_pc, w_fetch_base;
    logic          r_mem_fetch, r_err;
    logic          w_capture, w_pop1, w_pop2, w_illegal, w_space, w_issue;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == C_LAST) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        // A byte requested last cycle lands now unless a redirect discards it
        w_capture    = r_mem_fetch & ~pc_load;
        w_pop2       = consume2 & (r_count >= 4'd2);
        w_pop1       = consume1 & ~consume2 & (r_count != 4'd0);
        w_illegal    = (consume1 & consume2) | (consume2 & ~w_pop2)
                     | (consume1 & ~consume2 & ~w_pop1);
        w_rd_p1      = wrap_inc(r_rd_ptr);
        w_rd_next    = r_rd_ptr;
        if (w_pop2)
            w_rd_next = wrap_inc(w_rd_p1);
        else if (w_pop1)
            w_rd_next = w_rd_p1;
        if (pc_load)
            w_count_next = 4'd0;
        else
            w_count_next = r_count + {3'b000, w_capture} - {2'b00, w_pop2, w_pop1};
        // Space after this edge guarantees room for the byte a new request returns
        w_space      = (w_count_next < C_QDEPTH);
        w_fetch_base = pc_load ? pc_in : r_fetch_pc;

        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (ifu_enable)
                    w_state_next = w_space ? S_RUN : S_STALL;
            end
            S_RUN, S_STALL: begin
                if (!ifu_enable)
                    w_state_next = S_IDLE;
                else
                    w_state_next = w_space ? S_RUN : S_STALL;
            end
            default: w_state_next = S_IDLE;
        endcase
        w_issue = (w_state_next == S_RUN);
    end

    always_ff @(posedge clk_ifu) begin
        if (reset_ifu) begin
            r_state     <= S_IDLE;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= 4'd0;
            r_fetch_pc  <= RESET_PC;
            r_pc_head   <= RESET_PC;
            r_mem_pc    <= RESET_PC;
            r_mem_fetch <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_count     <= w_count_next;
            r_mem_fetch <= w_issue;
            if (w_illegal)
                r_err <= 1'b1;
            if (pc_load) begin
                r_rd_ptr  <= '0;
                r_wr_ptr  <= '0;
                r_pc_head <= pc_in;
            end else begin
                if (w_capture)
                    r_wr_ptr <= wrap_inc(r_wr_ptr);
                r_rd_ptr  <= w_rd_next;
                r_pc_head <= r_pc_head + {30'd0, w_pop2, w_pop1};
            end
            if (w_issue) begin
                r_mem_pc   <= w_fetch_base;
                r_fetch_pc <= w_fetch_base + 32'd1;
            end else if (pc_load) begin
                r_fetch_pc <= pc_in;
            end
        end
    end

    always_ff @(posedge clk_ifu) begin
        if (!reset_ifu && w_capture)
            r_q[r_wr_ptr] <= mem_byte;
    end

    assign mem_pc        = r_mem_pc;
    assign mem_fetch     = r_mem_fetch;
    assign mbr1_valid    = (r_count != 4'd0);
    assign mbr2_valid    = (r_count >= 4'd2);
    assign mbr1          = mbr1_valid ? r_q[r_rd_ptr] : 8'h00;
    assign mbr2          = mbr2_valid ? {r_q[r_rd_ptr], r_q[w_rd_p1]} : 16'h0000;
    assign pc_head       = r_pc_head;
    assign q_count       = r_count;
    assign err_underflow = r_err;
endmodule
`default_nettype wire

// File: tb/tb_fetch_ifu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ifu_ctrl
// Function : scoreboard bench for fetch_ifu_ctrl against an address-stream model
// Revision : 1.0
// ============================================================================
module tb_fetch_ifu_ctrl;
    localparam int QD = 6;

    logic        clk_ifu = 1'b0;
    logic        reset_ifu = 1'b1, ifu_enable = 1'b0, pc_load = 1'b0;
    logic        consume1 = 1'b0, consume2 = 1'b0;
    logic [31:0] pc_in = '0;
    logic [7:0]  mem_byte = '0;
    logic [31:0] mem_pc, pc_head;
    logic        mem_fetch, mbr1_valid, mbr2_valid, err_underflow;
    logic [7:0]  mbr1;
    logic [15:0] mbr2;
    logic [3:0]  q_count;

    fetch_ifu_ctrl #(.QDEPTH(QD), .RESET_PC(32'd0)) dut (
        .clk_ifu(clk_ifu), .reset_ifu(reset_ifu), .ifu_enable(ifu_enable),
        .pc_load(pc_load), .pc_in(pc_in), .mem_pc(mem_pc), .mem_fetch(mem_fetch),
        .mem_byte(mem_byte), .mbr1(mbr1), .mbr1_valid(mbr1_valid), .mbr2(mbr2),
        .mbr2_valid(mbr2_valid), .consume1(consume1), .consume2(consume2),
        .pc_head(pc_head), .q_count(q_count), .err_underflow(err_underflow)
    );

    always #5 clk_ifu = ~clk_ifu;

    typedef struct {
        logic [15:0] data;
        logic        two;
        logic [31:0] pc;
    } sb_t;

    sb_t         sb[$];
    int          checks = 0, errors = 0;
    logic [31:0] model_pc = '0;
    logic        err_cur = 1'b0, err_nxt = 1'b0, skip = 1'b1, mon_en = 1'b0;

    function automatic logic [7:0] mem_model(input logic [31:0] a);
        case (a)
            32'd0: return 8'h00;  32'd1: return 8'h0C;  32'd2:  return 8'h1D;  32'd3:  return 8'h0C;
            32'd4: return 8'h1E;  32'd5: return 8'h0C;  32'd6:  return 8'h15;  32'd7:  return 8'h0C;
            32'd8: return 8'h17;  32'd9: return 8'h17;  32'd10: return 8'h06;  32'd11: return 8'h03;
            default: return (a[7:0] * 8'd37) ^ a[15:8] ^ a[31:24] ^ 8'h5A;
        endcase
    endfunction

    // Memory samples on the falling edge; data is presented until the next sample
    always @(negedge clk_ifu) begin
        if (mem_fetch)
            mem_byte = mem_model(mem_pc);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk_ifu);
        err_cur = err_nxt;
    endtask

    task automatic drive(input logic en, input logic c1, input logic c2,
                         input logic pl, input logic rst, input logic [31:0] pin);
        sb_t e;
        reset_ifu  = rst;
        ifu_enable = en;
        consume1   = c1;
        consume2   = c2;
        pc_load    = pl;
        pc_in      = pin;
        skip       = pl | rst;
        if (rst) begin
            model_pc = 32'd0;
            err_nxt  = 1'b0;
        end else if (pl) begin
            model_pc = pin;
        end else if (c2) begin
            if (c1 || !mbr2_valid)
                err_nxt = 1'b1;
            if (mbr2_valid) begin
                e.data = {mem_model(model_pc), mem_model(model_pc + 32'd1)};
                e.two  = 1'b1;
                e.pc   = model_pc;
                sb.push_back(e);
                model_pc = model_pc + 32'd2;
            end
        end else if (c1) begin
            if (mbr1_valid) begin
                e.data = {8'h00, mem_model(model_pc)};
                e.two  = 1'b0;
                e.pc   = model_pc;
                sb.push_back(e);
                model_pc = model_pc + 32'd1;
            end else begin
                err_nxt = 1'b1;
            end
        end
    endtask

    task automatic step(input logic en, input logic c1, input logic c2,
                        input logic pl, input logic rst, input logic [31:0] pin);
        tick();
        drive(en, c1, c2, pl, rst, pin);
    endtask

    // Monitor: late in each cycle, check accepted bytes against the scoreboard
    always @(negedge clk_ifu) begin
        sb_t e;
        #4;
        if (mon_en) begin
            if (!reset_ifu && !pc_load &&
                ((consume2 && mbr2_valid) || (consume1 && !consume2 && mbr1_valid))) begin
                if (sb.size() == 0) begin
                    chk("sb_underrun", 32'd0, 32'd1);
                end else begin
                    e = sb.pop_front();
                    if (e.two)
                        chk("mbr2_data", {16'h0, mbr2}, {16'h0, e.data});
                    else
                        chk("mbr1_data", {24'h0, mbr1}, {24'h0, e.data[7:0]});
                    chk("pc_head_pop", pc_head, e.pc);
                end
            end else if (!skip) begin
                chk("pc_head", pc_head, model_pc);
            end
            chk("err_underflow", {31'd0, err_underflow}, {31'd0, err_cur});
            chk("valid1", {31'd0, mbr1_valid}, {31'd0, (q_count >= 4'd1)});
            chk("valid2", {31'd0, mbr2_valid}, {31'd0, (q_count >= 4'd2)});
            chk("count_bound", {31'd0, (q_count <= 4'(QD))}, 32'd1);
            if (!mbr1_valid) chk("mbr1_zero", {24'h0, mbr1}, 32'd0);
            if (!mbr2_valid) chk("mbr2_zero", {16'h0, mbr2}, 32'd0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int          nf, got, ref_cnt;
        logic        en, c1, c2, pl;
        logic [31:0] pin;
        int          r;

        step(0, 0, 0, 0, 1, 0);
        mon_en = 1'b1;
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("rst_count", {28'd0, q_count}, 32'd0);
        chk("rst_fetch", {31'd0, mem_fetch}, 32'd0);
        chk("rst_mem_pc", mem_pc, 32'd0);
        chk("rst_mbr1", {24'd0, mbr1}, 32'd0);
        chk("rst_mbr2", {16'd0, mbr2}, 32'd0);
        chk("rst_pc_head", pc_head, 32'd0);

        // Fill from reset: sequential addresses, stop at QDEPTH
        nf = 0;
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 0, 0, 0, 0);
            if (mem_fetch) begin
                chk("fill_addr", mem_pc, 32'(nf));
                nf++;
            end
        end
        chk("fill_fetches", 32'(nf), 32'(QD));
        chk("fill_count", {28'd0, q_count}, 32'(QD));
        chk("fill_mbr1", {24'd0, mbr1}, 32'h00);
        chk("fill_mbr2", {16'd0, mbr2}, 32'h000C);

        // Consume from full and watch the refill resume at address 6
        step(1, 1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        chk("c1_mbr1", {24'd0, mbr1}, 32'h0C);
        chk("c1_pc_head", pc_head, 32'd1);
        chk("resume_fetch", {31'd0, mem_fetch}, 32'd1);
        chk("resume_addr", mem_pc, 32'd6);
        step(1, 0, 0, 0, 0, 0);
        chk("c2_mbr1", {24'd0, mbr1}, 32'h0C);
        chk("c2_pc_head", pc_head, 32'd3);
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, 0);
        chk("refill_count", {28'd0, q_count}, 32'(QD));

        // Redirect with a fetch in flight: the in-flight byte must vanish
        step(1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 32'd8);
        chk("load_inflight", {31'd0, mem_fetch}, 32'd1);
        step(1, 0, 0, 0, 0, 0);
        chk("load_empty", {31'd0, mbr1_valid}, 32'd0);
        chk("load_addr", mem_pc, 32'd8);
        step(1, 0, 0, 0, 0, 0);
        chk("load_mbr1", {24'd0, mbr1}, 32'h17);
        step(1, 0, 0, 0, 0, 0);
        chk("load_mbr2", {16'd0, mbr2}, 32'h1717);
        chk("load_pc_head", pc_head, 32'd8);

        // Illegal consume2 with a single byte held
        step(1, 0, 0, 1, 0, 32'h100);
        got = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!got && q_count == 4'd1) begin
                drive(1, 0, 1, 0, 0, 0);
                got = 1;
            end else begin
                drive(1, 0, 0, 0, 0, 0);
            end
            if (got == 1 && i < 9) begin
                step(1, 0, 0, 0, 0, 0);
                chk("underflow_set", {31'd0, err_underflow}, 32'd1);
                chk("underflow_pc", pc_head, 32'h100);
                got = 2;
            end
        end
        chk("underflow_seen", 32'(got), 32'd2);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0);
        chk("underflow_sticky", {31'd0, err_underflow}, 32'd1);

        // Steady consume1 from a full queue after a fresh reset
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("rst2_err", {31'd0, err_underflow}, 32'd0);
        for (int i = 0; i < 12; i++) step(1, 0, 0, 0, 0, 0);
        ref_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            step(1, mbr1_valid, 0, 0, 0, 0);
            if (i == 2) ref_cnt = int'(q_count);
            if (i > 2) chk("steady_count", {28'd0, q_count}, 32'(ref_cnt));
        end

        // Fetch address wrap
        step(1, 0, 0, 1, 0, 32'hFFFF_FFFE);
        step(1, 0, 0, 0, 0, 0);
        chk("wrap_a0", mem_pc, 32'hFFFF_FFFE);
        step(1, 0, 0, 0, 0, 0);
        chk("wrap_a1", mem_pc, 32'hFFFF_FFFF);
        step(1, 0, 0, 0, 0, 0);
        chk("wrap_a2", mem_pc, 32'h0000_0000);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            tick();
            en  = ($urandom_range(0, 9) != 0);
            pl  = ($urandom_range(0, 49) == 0);
            pin = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : $urandom;
            r   = int'($urandom_range(0, 3));
            c2  = !pl && (r == 2) && mbr2_valid;
            c1  = !pl && (r == 1) && mbr1_valid;
            drive(en, c1, c2, pl, 0, pin);
        end
        step(1, 0, 0, 0, 0, 0);
        chk("sb_drained", sb.size(), 32'd0);

        // Reset mid-operation with four bytes held and one in flight
        step(1, 0, 0, 1, 0, 32'h40);
        got = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (!got && q_count == 4'd4 && mem_fetch) begin
                drive(0, 0, 0, 0, 1, 0);
                got = 1;
            end else begin
                drive(got ? 1'b0 : 1'b1, 0, 0, 0, 0, 0);
            end
        end
        chk("midrst_seen", 32'(got), 32'd1);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("midrst_count", {28'd0, q_count}, 32'd0);
        chk("midrst_fetch", {31'd0, mem_fetch}, 32'd0);
        chk("midrst_pc_head", pc_head, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0);
            chk("idle_fetch", {31'd0, mem_fetch}, 32'd0);
        end
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("restart_fetch", {31'd0, mem_fetch}, 32'd1);
        chk("restart_addr", mem_pc, 32'd0);

        step(0, 0, 0, 0, 0, 0);
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
